// File: rtl/exe_mem_pipe_reg_pkg.sv
// Shared definitions for the EXE->MEM elastic stage register: default widths,
// payload layout helpers and the reset level.
package pipe_pkg;

    localparam int   DATA_W_DEF = 32;
    localparam int   DEST_W_DEF = 4;
    localparam int   CNT_W_DEF  = 16;
    localparam int   CTRL_W     = 3;
    localparam logic RST_ACTIVE = 1'b0;

    // Payload layout, MSB first: {WB_en, MEM_R_EN, MEM_W_EN, ALU_result, ST_val, Dest}
    function automatic int payload_w(input int data_w, input int dest_w);
        return CTRL_W + 2 * data_w + dest_w;
    endfunction

    localparam int PAYLOAD_W = payload_w(DATA_W_DEF, DEST_W_DEF);

    typedef struct packed {
        logic wb_en;
        logic mem_r_en;
        logic mem_w_en;
    } ctrl_t;

endpackage

// File: rtl/exe_mem_pipe_reg_entry.sv
// One storage slot of the stage register: a payload register plus its valid bit.
// clr drops the valid bit only; the payload is left as-is.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int W = PAYLOAD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (ld_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// Elastic EXE->MEM stage register with optional skid slot, flush, forwarding tap
// and a saturating back-pressure counter.
module exe_mem_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEST_W = DEST_W_DEF,
    parameter int SKID   = 1,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              WB_en_in,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic [DATA_W-1:0] ST_val_in,
    input  logic [DEST_W-1:0] Dest_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              WB_en,
    output logic              MEM_R_EN,
    output logic              MEM_W_EN,
    output logic [DATA_W-1:0] ALU_result,
    output logic [DATA_W-1:0] ST_val,
    output logic [DEST_W-1:0] Dest,
    output logic              fwd_valid,
    output logic [DEST_W-1:0] fwd_dest,
    output logic [DATA_W-1:0] fwd_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int              PW      = payload_w(DATA_W, DEST_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PW-1:0]    in_payload;
    logic [PW-1:0]    h_data, s_data, h_din;
    logic             h_v, s_v;
    logic             h_ld, h_vin, s_ld, s_vin;
    logic             h_vn, s_vn;
    logic             accept, pop;
    logic [1:0]       occ_d, occ_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    ctrl_t            h_ctrl;

    assign in_payload = {WB_en_in, MEM_R_EN_in, MEM_W_EN_in, ALU_result_in, ST_val_in, Dest_in};

    // Handshake: a beat moves on an edge where valid and ready are both high;
    // the producer holds its payload stable while valid is high and ready is low.
    assign in_ready = (SKID != 0) ? ~s_v : (~h_v | out_ready);
    assign accept   = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

    always_comb begin
        h_ld  = 1'b0;
        h_vin = 1'b0;
        h_din = in_payload;
        s_ld  = 1'b0;
        s_vin = 1'b0;
        if (SKID != 0) begin
            if (!h_v) begin
                h_ld  = accept;
                h_vin = 1'b1;
            end else if (pop) begin
                // Head refills from the skid slot first to keep FIFO order.
                h_ld  = 1'b1;
                h_vin = s_v | accept;
                h_din = s_v ? s_data : in_payload;
                s_ld  = 1'b1;
                s_vin = s_v & accept;
            end else if (accept) begin
                s_ld  = 1'b1;
                s_vin = 1'b1;
            end
        end else begin
            if (accept) begin
                h_ld  = 1'b1;
                h_vin = 1'b1;
            end else if (pop) begin
                h_ld  = 1'b1;
                h_vin = 1'b0;
            end
        end
    end

    pipe_entry #(.W(PW)) u_head (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (flush),
        .ld_i    (h_ld),
        .valid_i (h_vin),
        .data_i  (h_din),
        .valid_o (h_v),
        .data_o  (h_data)
    );

    pipe_entry #(.W(PW)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (flush),
        .ld_i    (s_ld),
        .valid_i (s_vin),
        .data_i  (in_payload),
        .valid_o (s_v),
        .data_o  (s_data)
    );

    assign h_vn  = flush ? 1'b0 : (h_ld ? h_vin : h_v);
    assign s_vn  = flush ? 1'b0 : (s_ld ? s_vin : s_v);
    assign occ_d = {1'b0, h_vn} + {1'b0, s_vn};
    assign cnt_d = (out_valid && !out_ready && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            occ_q <= 2'd0;
            cnt_q <= '0;
        end else begin
            occ_q <= occ_d;
            cnt_q <= cnt_d;
        end
    end

    assign h_ctrl     = h_data[PW-1 -: CTRL_W];
    assign out_valid  = h_v;
    assign WB_en      = h_ctrl.wb_en & h_v;
    assign MEM_R_EN   = h_ctrl.mem_r_en & h_v;
    assign MEM_W_EN   = h_ctrl.mem_w_en & h_v;
    assign ALU_result = h_data[DEST_W + DATA_W +: DATA_W];
    assign ST_val     = h_data[DEST_W +: DATA_W];
    assign Dest       = h_data[DEST_W-1:0];
    assign fwd_valid  = out_valid & WB_en & ~MEM_R_EN;
    assign fwd_dest   = Dest;
    assign fwd_data   = ALU_result;
    assign occupancy  = occ_q;
    assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Self-checking bench for exe_mem_pipe_reg (SKID=1, 4-bit stall counter).
module tb_exe_mem_pipe_reg;

  localparam int DW = 32;
  localparam int DSW = 4;
  localparam int CW = 4;
  localparam int PW = 3 + 2 * DW + DSW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          wb_en_in = 1'b0, mem_r_en_in = 1'b0, mem_w_en_in = 1'b0;
  logic [DW-1:0] alu_in = '0, st_in = '0;
  logic [DSW-1:0] dest_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          wb_en, mem_r_en, mem_w_en;
  logic [DW-1:0] alu_out, st_out;
  logic [DSW-1:0] dest_out;
  logic          fwd_valid;
  logic [DSW-1:0] fwd_dest;
  logic [DW-1:0] fwd_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;
  logic [PW-1:0] exp_q[$];

  exe_mem_pipe_reg #(.DATA_W(DW), .DEST_W(DSW), .SKID(1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .WB_en_in(wb_en_in), .MEM_R_EN_in(mem_r_en_in), .MEM_W_EN_in(mem_w_en_in),
    .ALU_result_in(alu_in), .ST_val_in(st_in), .Dest_in(dest_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .WB_en(wb_en), .MEM_R_EN(mem_r_en), .MEM_W_EN(mem_w_en),
    .ALU_result(alu_out), .ST_val(st_out), .Dest(dest_out),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    repeat (cycles) step();
    rst = 1'b1;
  endtask

  // driver: presents one beat for the next edge
  task automatic drive(input logic wb, input logic rd, input logic wr,
                       input logic [DW-1:0] alu, input logic [DW-1:0] st,
                       input logic [DSW-1:0] dst);
    in_valid = 1'b1;
    wb_en_in = wb;
    mem_r_en_in = rd;
    mem_w_en_in = wr;
    alu_in = alu;
    st_in = st;
    dest_in = dst;
  endtask

  // scoreboard: sampled mid-cycle, reflecting what the coming edge will do
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 1, 0);
        end else begin
          check("pop_payload", {wb_en, mem_r_en, mem_w_en, alu_out, st_out, dest_out}, exp_q.pop_front());
        end
      end
      if (flush) begin
        exp_q.delete();
      end else if (in_valid && in_ready) begin
        exp_q.push_back({wb_en_in, mem_r_en_in, mem_w_en_in, alu_in, st_in, dest_in});
      end
    end else begin
      exp_q.delete();
    end
  end

  initial begin
    // reset state
    do_reset(2);
    check("rst_out_valid", out_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_alu", alu_out, 0);
    check("rst_in_ready", in_ready, 1);

    // single accept: load to r5
    drive(0, 1, 0, 32'h0000_1000, 32'h0, 4'd5);
    step();
    in_valid = 1'b0;
    check("acc_out_valid", out_valid, 1);
    check("acc_mem_r_en", mem_r_en, 1);
    check("acc_dest", dest_out, 5);
    check("acc_fwd_valid_load", fwd_valid, 0);
    check("acc_occupancy", occupancy, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("acc_drained", out_valid, 0);

    // back-pressure fills head and skid slot
    drive(1, 0, 0, 32'h11, 32'hA, 4'd1);
    step();
    drive(1, 0, 0, 32'h22, 32'hB, 4'd2);
    step();
    in_valid = 1'b0;
    check("bp_in_ready", in_ready, 0);
    check("bp_occupancy", occupancy, 2);
    check("bp_stall_cnt_1", stall_cnt, 1);
    step();
    check("bp_stall_cnt_2", stall_cnt, 2);
    check("bp_head_stable", alu_out, 32'h11);
    out_ready = 1'b1;
    step();
    check("bp_second_valid", out_valid, 1);
    check("bp_second_alu", alu_out, 32'h22);
    check("bp_in_ready_back", in_ready, 1);
    step();
    check("bp_empty", occupancy, 0);

    // streaming at one beat per cycle
    do_reset(1);
    out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      drive(1, 0, $urandom_range(0, 1), DW'(i), DW'($urandom_range(0, 255)), DSW'(i));
      check("stream_in_ready", in_ready, 1);
      step();
      check("stream_out_valid", out_valid, 1);
      check("stream_alu", alu_out, i);
    end
    in_valid = 1'b0;
    step();
    check("stream_stall_cnt", stall_cnt, 0);
    check("stream_drained", out_valid, 0);

    // flush with both slots full and a beat offered
    out_ready = 1'b0;
    drive(1, 1, 1, 32'h33, 32'h3, 4'd7);
    step();
    drive(1, 1, 1, 32'h44, 32'h4, 4'd8);
    step();
    drive(1, 0, 1, 32'h55, 32'h5, 4'd9);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_ctrl", {wb_en, mem_r_en, mem_w_en}, 0);
    check("flush_occupancy", occupancy, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush_keeps_stall_cnt", stall_cnt, 2);

    // flush with one slot held: the offered beat is accepted by the handshake but discarded
    drive(1, 0, 0, 32'h66, 32'h6, 4'd10);
    step();
    drive(1, 0, 0, 32'h77, 32'h7, 4'd11);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_acc_out_valid", out_valid, 0);
    check("flush_acc_occupancy", occupancy, 0);
    check("flush_acc_stall_cnt", stall_cnt, 3);

    // forwarding tap
    drive(1, 0, 0, 32'hDEAD_BEEF, 32'h0, 4'd3);
    step();
    in_valid = 1'b0;
    check("fwd_valid", fwd_valid, 1);
    check("fwd_dest", fwd_dest, 3);
    check("fwd_data", fwd_data, 32'hDEAD_BEEF);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // counter saturation, then reset mid-stall
    drive(1, 0, 1, 32'h88, 32'h8, 4'd12);
    step();
    in_valid = 1'b0;
    repeat (20) step();
    check("sat_stall_cnt", stall_cnt, 15);
    check("sat_head_stable", alu_out, 32'h88);
    rst = 1'b0;
    step();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_payload", {wb_en, mem_r_en, mem_w_en, alu_out, st_out, dest_out}, 0);
    check("midrst_occupancy", occupancy, 0);
    check("midrst_stall_cnt", stall_cnt, 0);
    rst = 1'b1;
    step();
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exe_mem_pipe_reg.md
Name: exe_mem_pipe_reg

Overview:
Parametrised elastic successor to the fixed EXE→MEM stage register. It carries WB_en, MEM_R_EN, MEM_W_EN, ALU result, store value and destination register between EXE and MEM with a valid/ready handshake. It adds an optional skid entry, a flush for branch/exception squash, a forwarding tap and a saturating back-pressure counter. Used between EXE_stage and the MEM stage when MEM can stall, for example on a cache miss.

Parameters:
DATA_W, 32, width of ALU_result and ST_val
DEST_W, 4, width of Dest (register index)
SKID, 1, 1 = two-entry skid buffer (in_ready registered); 0 = single entry (in_ready combinational)
CNT_W, 16, width of stall_cnt

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
flush  in  1  squash all held entries
in_valid  in  1  EXE presents an instruction
in_ready  out  1  register can accept this cycle
WB_en_in  in  1  write-back enable
MEM_R_EN_in  in  1  load
MEM_W_EN_in  in  1  store
ALU_result_in  in  DATA_W  address or result
ST_val_in  in  DATA_W  store data
Dest_in  in  DEST_W  destination register
out_valid  out  1  MEM-side entry valid
out_ready  in  1  MEM consumes this cycle
WB_en, MEM_R_EN, MEM_W_EN  out  1 each  head-entry controls, gated by out_valid
ALU_result, ST_val  out  DATA_W each  head-entry data
Dest  out  DEST_W  head-entry destination
fwd_valid  out  1  out_valid & WB_en & ~MEM_R_EN
fwd_dest  out  DEST_W  equals Dest
fwd_data  out  DATA_W  equals ALU_result
occupancy  out  2  held entries: 0..2 with SKID=1, 0..1 with SKID=0
stall_cnt  out  CNT_W  cycles with out_valid & ~out_ready, saturating

Behaviour:
- Reset (rst=0 at a rising edge) clears every register: out_valid=0, all payload outputs 0, occupancy=0, stall_cnt=0. in_ready=1 in the cycle after reset. Reset has priority over flush and the handshakes.
- Accept happens when in_valid & in_ready. Pop happens when out_valid & out_ready. Both take effect at the next edge, so latency is 1 cycle from accept to out_valid when the register is empty.
- SKID=1: storage is a head entry H and a skid entry S; in_ready = ~S.valid, driven from a register.
  - H empty, accept: H <= input.
  - H full, pop, no accept: H <= S if S is valid, else H empties; S empties.
  - H full, pop and accept: if S is valid, H <= S and S <= input; otherwise H <= input.
  - H full, no pop, accept: S <= input, so in_ready drops next cycle.
  - Both entries full: in_ready=0 and no accept occurs.
  - Ordering is strictly FIFO.
- SKID=0: single entry. in_ready = ~out_valid | out_ready (combinational). A simultaneous pop and accept replaces the entry with no bubble.
- flush=1 at an edge: all entries are invalidated and an accept in the same cycle is discarded. The pop still counts toward the MEM side. Payload registers may hold stale data. Control outputs must read 0 whenever out_valid=0.
- Control outputs are gated, so a bubble is a NOP: WB_en = H.WB_en & out_valid, and the same for MEM_R_EN and MEM_W_EN.
- The payload must be held stable while out_valid & ~out_ready (stall).
- stall_cnt increments on every edge with out_valid & ~out_ready and saturates at 2^CNT_W−1. Only rst clears it; flush does not.
- occupancy equals the number of valid entries, registered.
- Load-use: fwd_valid=0 for loads (MEM_R_EN=1). The hazard unit must stall in that case.

Decomposition:
- Shared package (pipe_pkg): the payload struct/width constant PAYLOAD_W = 3+2*DATA_W+DEST_W, default widths, and a reset-value constant.
- One natural sub-module: pipe_entry. It is a PAYLOAD_W-bit register with valid, ld and clr inputs, reusing the codebase register. It is instantiated once for H and once for S.
- Top level: the handshake/next-state logic and the counter.

Test Plan:
- Reset then single accept: rst=0 for 2 cycles, then load ALU_result_in=0x0000_1000, Dest_in=5, MEM_R_EN_in=1 → next cycle out_valid=1, MEM_R_EN=1, Dest=5, fwd_valid=0, occupancy=1.
- Back-pressure, SKID=1: out_ready=0, push A=0x11 then B=0x22 → in_ready=0 after B, occupancy=2, stall_cnt increments each cycle. Release out_ready → outputs A then B in consecutive cycles with no bubble.
- Streaming: in_valid=out_ready=1 for 20 cycles with values 1..20 → outputs 1..20 in order at 1-cycle latency, in_ready stays 1, stall_cnt=0.
- Flush with 2 entries held plus a simultaneous accept → next cycle out_valid=0, WB_en=MEM_R_EN=MEM_W_EN=0, occupancy=0, in_ready=1.
- Forwarding: accept WB_en_in=1, MEM_R_EN_in=0, ALU_result_in=0xDEAD_BEEF, Dest_in=3 → fwd_valid=1, fwd_dest=3, fwd_data=0xDEADBEEF.
- Saturation with CNT_W=4: stall for 20 cycles → stall_cnt=15. Reset mid-stall → all outputs 0 on the next edge.
